// File: rtl/cordic_pkg.sv
`default_nettype none
//==============================================================================
// Module      : cordic_pkg
// Description : Shared widths, angle constants and FSM encoding for the
//               CORDIC arbiter slice.
// Revision    : 1.0 - initial release
//==============================================================================
package cordic_pkg;

    localparam int ANGLE_W = 32;
    localparam int DATA_W  = 32;

    // Angles are in units of 1e-7 degree.
    localparam logic signed [ANGLE_W-1:0] ANG_90  = 32'sd900_000_000;
    localparam logic signed [ANGLE_W-1:0] ANG_180 = 32'sd1_800_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_arbiter_rr_pick.sv
`default_nettype none
//==============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches from ptr+1 upward,
//               wrapping modulo N_REQ, and returns a one-hot grant plus index.
// Revision    : 1.0 - initial release
//==============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest valid
    // requester after ptr is the last writer and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_idx     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req_valid[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = ID_W'(w_idx);
                grant_any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : cordic_arbiter
// Description : Shares one 16-iteration sine/cosine CORDIC engine between
//               N_REQ requesters with round-robin arbitration and a tagged
//               valid/ready response bus. Optional quadrant folding of
//               +-180 degree inputs is enabled by CORDIC_ARB_RANGE_REDUCE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [ANGLE_W*N_REQ-1:0]    req_angle,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic signed [DATA_W-1:0]    rsp_sine,
    output logic signed [DATA_W-1:0]    rsp_cosine,
    output logic                        eng_s,
    output logic signed [ANGLE_W-1:0]   eng_angle,
    input  logic                        eng_done,
    input  logic signed [DATA_W-1:0]    eng_sine,
    input  logic signed [DATA_W-1:0]    eng_cosine
);

    arb_state_t                 r_state;
    logic [ID_W-1:0]            r_ptr;
    logic                       r_fold;

    logic [N_REQ-1:0]           w_grant;
    logic [ID_W-1:0]            w_grant_idx;
    logic                       w_grant_any;
    logic                       w_accept;
    logic signed [ANGLE_W-1:0]  w_sel_angle;
    logic signed [ANGLE_W-1:0]  w_drive_angle;
    logic                       w_fold;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    always_comb begin
        w_sel_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_angle = req_angle[ANGLE_W*i +: ANGLE_W];
            end
        end
    end

`ifdef CORDIC_ARB_RANGE_REDUCE_EN
    // Reflect about +-90 degrees: sine is preserved, cosine changes sign.
    always_comb begin
        w_fold        = 1'b0;
        w_drive_angle = w_sel_angle;
        if (w_sel_angle > ANG_90) begin
            w_fold        = 1'b1;
            w_drive_angle = ANG_180 - w_sel_angle;
        end else if (w_sel_angle < -ANG_90) begin
            w_fold        = 1'b1;
            w_drive_angle = -ANG_180 - w_sel_angle;
        end
    end
`else
    assign w_fold        = 1'b0;
    assign w_drive_angle = w_sel_angle;
`endif

    // The accept pulse must coincide with the grant decision in IDLE, so it
    // is decoded from the state register rather than registered itself.
    assign w_accept  = (r_state == IDLE) && w_grant_any && !eng_done && !rst;
    assign req_ready = w_accept ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= ID_W'(N_REQ - 1);
            r_fold     <= 1'b0;
            eng_s      <= 1'b0;
            eng_angle  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sine   <= '0;
            rsp_cosine <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ptr     <= w_grant_idx;
                        r_fold    <= w_fold;
                        eng_angle <= w_drive_angle;
                        eng_s     <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        eng_s      <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= r_ptr;
                        rsp_sine   <= eng_sine;
                        rsp_cosine <= r_fold ? -eng_cosine : eng_cosine;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_cordic_arbiter
// Description : Directed bench for cordic_arbiter with a table-driven
//               16-iteration engine stand-in.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_cordic_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [32*N_REQ-1:0]    req_angle;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic signed [31:0]     rsp_sine;
    logic signed [31:0]     rsp_cosine;
    logic                   eng_s;
    logic signed [31:0]     eng_angle;
    logic                   eng_done;
    logic signed [31:0]     eng_sine;
    logic signed [31:0]     eng_cosine;

    logic [4:0]             r_eng_cnt;
    int                     checks = 0;
    int                     errors = 0;
    int                     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sine   (rsp_sine),
        .rsp_cosine (rsp_cosine),
        .eng_s      (eng_s),
        .eng_angle  (eng_angle),
        .eng_done   (eng_done),
        .eng_sine   (eng_sine),
        .eng_cosine (eng_cosine)
    );

    // Engine stand-in: done rises 17 cycles after s, drops once s is low.
    always_ff @(posedge clk) begin
        if (rst || !eng_s) begin
            r_eng_cnt <= '0;
            eng_done  <= 1'b0;
        end else if (r_eng_cnt == 5'd16) begin
            eng_done  <= 1'b1;
        end else begin
            r_eng_cnt <= r_eng_cnt + 5'd1;
        end
    end

    always_comb begin
        eng_sine   = 32'sd123;
        eng_cosine = -32'sd456;
        case (eng_angle)
            32'sd0:            begin eng_sine = 32'sd0;         eng_cosine = 32'sd10_000_000; end
            32'sd300_000_000:  begin eng_sine = 32'sd5_000_000; eng_cosine = 32'sd8_660_254;  end
            32'sd450_000_000:  begin eng_sine = 32'sd7_071_068; eng_cosine = 32'sd7_071_068;  end
            32'sd600_000_000:  begin eng_sine = 32'sd8_660_254; eng_cosine = 32'sd5_000_000;  end
            32'sd900_000_000:  begin eng_sine = 32'sd10_000_000; eng_cosine = 32'sd0;         end
            -32'sd300_000_000: begin eng_sine = -32'sd5_000_000; eng_cosine = 32'sd8_660_254; end
            -32'sd600_000_000: begin eng_sine = -32'sd8_660_254; eng_cosine = 32'sd5_000_000; end
            default: ;
        endcase
    end

    task automatic set_angle(input int i, input logic signed [31:0] a);
        req_angle[32*i +: 32] = a;
    endtask

    // Returns the granted index, or -1 if no accept pulse appears in time.
    task automatic wait_grant(output int g);
        bit found;
        g     = -1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            #1;
            if (req_ready != '0) begin
                found = 1'b1;
                for (int k = 0; k < N_REQ; k++) if (req_ready[k]) g = k;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Called in cycle 1 of a job; returns the cycle in which rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_angle = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== '0)  begin errors++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (eng_s !== 1'b0)     begin errors++; $display("FAIL reset_eng_s got %b want 0", eng_s); end
        checks++; if (eng_angle !== '0 || rsp_id !== '0 || rsp_sine !== '0 || rsp_cosine !== '0) begin
            errors++; $display("FAIL reset_data got ang=%0d id=%0d s=%0d c=%0d want all 0", eng_angle, rsp_id, rsp_sine, rsp_cosine);
        end
    endtask

    task automatic test_single;
        int g, lat;
        @(negedge clk);
        set_angle(1, 32'sd300_000_000);
        req_valid = 4'b0010;
        wait_grant(g);
        checks++; if (g != 1) begin errors++; $display("FAIL single_grant got %0d want 1", g); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (eng_s !== 1'b1 || eng_angle !== 32'sd300_000_000) begin
            errors++; $display("FAIL single_eng got s=%b ang=%0d want s=1 ang=300000000", eng_s, eng_angle);
        end
        wait_rsp(lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL single_latency got %0d want 19", lat); end
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL single_id got %0d want 1", rsp_id); end
        checks++; if (rsp_sine !== 32'sd5_000_000) begin errors++; $display("FAIL single_sine got %0d want 5000000", rsp_sine); end
        checks++; if (rsp_cosine !== 32'sd8_660_254) begin errors++; $display("FAIL single_cosine got %0d want 8660254", rsp_cosine); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || eng_s !== 1'b0) begin
            errors++; $display("FAIL single_done got rsp_valid=%b eng_s=%b want 0 0", rsp_valid, eng_s);
        end
    endtask

    task automatic test_all_four;
        int g, lat, prev;
        int exp_s[4] = '{0, 5_000_000, 7_071_068, -8_660_254};
        int exp_c[4] = '{10_000_000, 8_660_254, 7_071_068, 5_000_000};
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_angle(0, 32'sd0);
        set_angle(1, 32'sd300_000_000);
        set_angle(2, 32'sd450_000_000);
        set_angle(3, -32'sd600_000_000);
        req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            checks++; if (g != k) begin errors++; $display("FAIL all_grant%0d got %0d want %0d", k, g, k); end
            if (k > 0) begin
                checks++; if (cyc - prev != 20) begin errors++; $display("FAIL all_spacing%0d got %0d want 20", k, cyc - prev); end
            end
            prev = cyc;
            @(negedge clk);
            if (g >= 0) req_valid[g] = 1'b0;
            wait_rsp(lat);
            checks++; if (lat != 19) begin errors++; $display("FAIL all_latency%0d got %0d want 19", k, lat); end
            checks++; if (rsp_id !== ID_W'(k) || rsp_sine !== exp_s[k] || rsp_cosine !== exp_c[k]) begin
                errors++; $display("FAIL all_result%0d got id=%0d s=%0d c=%0d want id=%0d s=%0d c=%0d",
                                   k, rsp_id, rsp_sine, rsp_cosine, k, exp_s[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_fairness;
        int g, lat, want;
        @(negedge clk);
        set_angle(0, 32'sd900_000_000);
        set_angle(2, -32'sd300_000_000);
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 0 : 2;
            wait_grant(g);
            checks++; if (g != want) begin errors++; $display("FAIL fair_grant%0d got %0d want %0d", k, g, want); end
            @(negedge clk);
            if (k == 5) req_valid = '0;
            wait_rsp(lat);
            checks++; if (rsp_id !== ID_W'(want) || rsp_sine !== ((want == 0) ? 32'sd10_000_000 : -32'sd5_000_000)) begin
                errors++; $display("FAIL fair_result%0d got id=%0d s=%0d want id=%0d", k, rsp_id, rsp_sine, want);
            end
        end
    endtask

    task automatic test_backpressure;
        int g, lat;
        @(negedge clk);
        set_angle(3, 32'sd600_000_000);
        set_angle(1, 32'sd0);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        wait_grant(g);
        checks++; if (g != 3) begin errors++; $display("FAIL bp_grant got %0d want 3", g); end
        @(negedge clk);
        req_valid = 4'b0010;
        wait_rsp(lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL bp_latency got %0d want 19", lat); end
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sine !== 32'sd8_660_254 ||
                rsp_cosine !== 32'sd5_000_000 || req_ready !== '0 || eng_s !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b id=%0d s=%0d c=%0d rdy=%h eng_s=%b want v=1 id=3 s=8660254 c=5000000 rdy=0 eng_s=0",
                                   i, rsp_valid, rsp_id, rsp_sine, rsp_cosine, req_ready, eng_s);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%h want v=1 rdy=0", rsp_valid, req_ready);
        end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_after got v=%b rdy=%h want v=0 rdy=2", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        checks++; if (rsp_id !== 2'd1 || rsp_sine !== 32'sd0 || rsp_cosine !== 32'sd10_000_000) begin
            errors++; $display("FAIL bp_next got id=%0d s=%0d c=%0d want id=1 s=0 c=10000000", rsp_id, rsp_sine, rsp_cosine);
        end
    endtask

    task automatic test_range;
        int g, lat;
        @(negedge clk);
`ifdef CORDIC_ARB_RANGE_REDUCE_EN
        set_angle(0, 32'sd1_500_000_000);
        req_valid = 4'b0001;
        wait_grant(g);
        checks++; if (g != 0) begin errors++; $display("FAIL fold_pos_grant got %0d want 0", g); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (eng_angle !== 32'sd300_000_000) begin errors++; $display("FAIL fold_pos_angle got %0d want 300000000", eng_angle); end
        wait_rsp(lat);
        checks++; if (rsp_sine !== 32'sd5_000_000 || rsp_cosine !== -32'sd8_660_254) begin
            errors++; $display("FAIL fold_pos_result got s=%0d c=%0d want s=5000000 c=-8660254", rsp_sine, rsp_cosine);
        end
        @(negedge clk);
        set_angle(0, -32'sd1_200_000_000);
        req_valid = 4'b0001;
        wait_grant(g);
        @(negedge clk);
        req_valid = '0;
        checks++; if (eng_angle !== -32'sd600_000_000) begin errors++; $display("FAIL fold_neg_angle got %0d want -600000000", eng_angle); end
        wait_rsp(lat);
        checks++; if (rsp_sine !== -32'sd8_660_254 || rsp_cosine !== -32'sd5_000_000) begin
            errors++; $display("FAIL fold_neg_result got s=%0d c=%0d want s=-8660254 c=-5000000", rsp_sine, rsp_cosine);
        end
`else
        set_angle(0, 32'sd1_500_000_000);
        req_valid = 4'b0001;
        wait_grant(g);
        checks++; if (g != 0) begin errors++; $display("FAIL pass_grant got %0d want 0", g); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (eng_angle !== 32'sd1_500_000_000) begin errors++; $display("FAIL pass_angle got %0d want 1500000000", eng_angle); end
        wait_rsp(lat);
        checks++; if (lat != 19 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL pass_handshake got lat=%0d id=%0d want lat=19 id=0", lat, rsp_id);
        end
`endif
    endtask

    task automatic test_reset_mid_run;
        int g, lat, rel;
        @(negedge clk);
        set_angle(2, 32'sd450_000_000);
        req_valid = 4'b0100;
        wait_grant(g);
        @(negedge clk);
        req_valid = '0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        rel = cyc;
        checks++;
        if (eng_s !== 1'b0 || eng_angle !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 ||
            rsp_sine !== '0 || rsp_cosine !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL midrst_outputs got s=%b ang=%0d v=%b id=%0d sn=%0d cs=%0d rdy=%h want all 0",
                               eng_s, eng_angle, rsp_valid, rsp_id, rsp_sine, rsp_cosine, req_ready);
        end
        set_angle(0, 32'sd300_000_000);
        set_angle(3, 32'sd900_000_000);
        req_valid = 4'b1001;
        wait_grant(g);
        checks++; if (g != 0 || cyc != rel) begin
            errors++; $display("FAIL midrst_grant got idx=%0d delay=%0d want idx=0 delay=0", g, cyc - rel);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(lat);
        checks++; if (lat != 19 || rsp_id !== 2'd0 || rsp_sine !== 32'sd5_000_000 || rsp_cosine !== 32'sd8_660_254) begin
            errors++; $display("FAIL midrst_job0 got lat=%0d id=%0d s=%0d c=%0d want lat=19 id=0 s=5000000 c=8660254",
                               lat, rsp_id, rsp_sine, rsp_cosine);
        end
        wait_grant(g);
        checks++; if (g != 3) begin errors++; $display("FAIL midrst_grant3 got %0d want 3", g); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(lat);
        checks++; if (rsp_id !== 2'd3 || rsp_sine !== 32'sd10_000_000 || rsp_cosine !== 32'sd0) begin
            errors++; $display("FAIL midrst_job3 got id=%0d s=%0d c=%0d want id=3 s=10000000 c=0", rsp_id, rsp_sine, rsp_cosine);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_all_four;
        test_fairness;
        test_backpressure;
        test_range;
        test_reset_mid_run;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares one 16-iteration sine/cosine CORDIC engine between N_REQ requesters. Arbitrates round-robin, drives the engine's level-held start / done handshake, and captures the engine's results. Returns each result on a single valid/ready response bus tagged with the requester index. The block sits between client datapaths and the engine; the engine is instantiated beside it and shares its clk and rst.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- ID_W, default 2: width of the response tag; must satisfy 2^ID_W ≥ N_REQ.
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- req_valid, in, N_REQ: per-requester request pending.
- req_angle, in, 32*N_REQ: signed angles, one per requester; slice i is bits [32i+31:32i]; units are 1e-7 degree.
- req_ready, out, N_REQ: one-hot, one-cycle accept pulse.
- rsp_valid, out, 1: result available.
- rsp_ready, in, 1: consumer accepts the result.
- rsp_id, out, ID_W: index of the requester that owns the result.
- rsp_sine, out, 32: signed sine, scaled ×1e7.
- rsp_cosine, out, 32: signed cosine, scaled ×1e7.
- eng_s, out, 1: engine start; level held.
- eng_angle, out, 32: angle driven to the engine.
- eng_done, in, 1: engine done.
- eng_sine, in, 32: engine sine result.
- eng_cosine, in, 32: engine cosine result.

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant condition: at least one req_valid is set and eng_done=0.
  - On grant: pulse req_ready[g]; latch req_angle slice g, the index g and the fold flag; update the round-robin pointer to g; go to RUN.
- RUN:
  - eng_s=1 and eng_angle=latched angle, both held constant for the whole state.
  - When eng_done=1: capture eng_sine and eng_cosine (apply fold negation); go to RESP.
- RESP:
  - eng_s=0; rsp_valid=1.
  - rsp_id, rsp_sine and rsp_cosine are held stable until rsp_valid && rsp_ready; then go to IDLE.
- Round-robin:
  - Search starts at pointer+1 and wraps modulo N_REQ.
  - The pointer resets to N_REQ-1, so requester 0 wins first.
  - A requester that is continuously valid cannot be granted twice in a row while another requester is valid.
- req_valid dropping before its grant: the request is simply not granted; no state is kept.
- Requester obligation: req_angle must be stable while req_valid is high.
- Arithmetic:
  - All values 32-bit signed.
  - Fold negation is two's complement. Result magnitudes are ≤ 1.1e7, so negation cannot overflow.
- Reset: clears the FSM to IDLE, sets the pointer to N_REQ-1, and drives every output to 0 (req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine, eng_s, eng_angle). rst is also the engine's reset, so a reset mid-RUN aborts both blocks cleanly.

## Timing
- Cycle 0: req_ready pulse (IDLE).
- Cycles 1..18: RUN. eng_s rises in cycle 1; with the 16-iteration engine, eng_done rises in cycle 18.
- Cycle 19: rsp_valid=1 (first cycle of RESP).
- Minimum request-to-request spacing is 20 cycles. Each extra cycle of rsp_ready=0 extends it by one.
- eng_s stays low for at least 2 cycles (RESP plus IDLE) between jobs. This satisfies the engine's requirement that s be low for it to return to idle.
- rsp_valid=1 with rsp_ready=1 in the same cycle: the transfer completes and the FSM is in IDLE the next cycle. There is no back-to-back grant inside RESP.

## Configuration
- Macro: CORDIC_ARB_RANGE_REDUCE_EN.
- Defined, input range ±1_800_000_000:
  - angle > 900_000_000: drive 1_800_000_000 − angle.
  - angle < −900_000_000: drive −1_800_000_000 − angle.
  - For either folded case, rsp_cosine = −eng_cosine and rsp_sine = eng_sine.
  - The fold is computed combinationally at the grant and latched.
- Undefined: the angle passes through unchanged and the valid input range is ±900_000_000. Out-of-range inputs give unspecified values, but the handshake still completes.

## Structure
- Shared package cordic_pkg holds:
  - ANGLE_W=32 and DATA_W=32.
  - The angle constants ANG_90 = 900_000_000 and ANG_180 = 1_800_000_000.
  - The FSM state enum.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req_valid and the pointer; outputs are a grant one-hot plus its index.

## Test plan
- Single request:
  - Stimulus: req 1 at 300_000_000.
  - Response: req_ready[1] in cycle 0; rsp_valid in cycle 19; rsp_id=1; rsp_sine = 5_000_000 ±20_000; rsp_cosine = 8_660_254 ±20_000.
- All four requesters valid after reset: grants in order 0, 1, 2, 3, with rsp_id in the same order and each result correct for its angle.
- Fairness:
  - Stimulus: req 0 and req 2 held valid for 6 jobs.
  - Response: grants alternate 0, 2, 0, 2, 0, 2.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles in RESP.
  - Response: outputs stable, no req_ready pulse, eng_s=0; transfer completes on the first rsp_ready=1.
- With CORDIC_ARB_RANGE_REDUCE_EN:
  - Angle 1_500_000_000 → eng_angle = 300_000_000; rsp_sine ≈ 5_000_000; rsp_cosine ≈ −8_660_254.
  - Angle −1_200_000_000 → rsp_sine ≈ −8_660_254; rsp_cosine ≈ −5_000_000.
- Reset mid-RUN:
  - Stimulus: rst asserted in cycle 8.
  - Response: next cycle all outputs are 0 and the FSM is in IDLE; the following request is served correctly, with requester 0 first.
